// File: rtl/spk_pkg.sv
// Purpose : shared codes, FSM state type and half-period table for the speaker arbiter.
// Latency : n/a (constants and a pure combinational function).
// Backpressure: n/a.
// Contents: note codes, octave codes, mode codes, arb_state_t, hp_of(note, oct).
package spk_pkg;

  localparam logic [2:0] N_SPACE = 3'd0;
  localparam logic [2:0] N_DO    = 3'd1;
  localparam logic [2:0] N_RE    = 3'd2;
  localparam logic [2:0] N_MI    = 3'd3;
  localparam logic [2:0] N_FA    = 3'd4;
  localparam logic [2:0] N_SO    = 3'd5;
  localparam logic [2:0] N_LA    = 3'd6;
  localparam logic [2:0] N_SI    = 3'd7;

  // Any octave code other than these two plays the middle octave.
  localparam logic [1:0] OCT_LOW  = 2'b10;
  localparam logic [1:0] OCT_HIGH = 2'b01;

  localparam logic [2:0] MODE_FREE   = 3'b001;
  localparam logic [2:0] MODE_AUTO   = 3'b010;
  localparam logic [2:0] MODE_STUDY  = 3'b100;
  localparam logic [2:0] MODE_RECORD = 3'b011;
  localparam logic [2:0] MODE_ADJUST = 3'b101;
  localparam logic [2:0] MODE_READ   = 3'b111;

  // Wide enough for the low-octave "do" (381680 cycles).
  localparam int HP_BITS = 19;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } arb_state_t;

  // Half-period in clk cycles at 100 MHz; the space note yields 0.
  function automatic logic [HP_BITS-1:0] hp_of(input logic [2:0] note, input logic [1:0] oct);
    logic [HP_BITS-1:0] mid;
    mid = '0;
    case (note)
      N_DO:    mid = 19'd190840;
      N_RE:    mid = 19'd170068;
      N_MI:    mid = 19'd151515;
      N_FA:    mid = 19'd143266;
      N_SO:    mid = 19'd127551;
      N_LA:    mid = 19'd113636;
      N_SI:    mid = 19'd101214;
      default: mid = '0;
    endcase
    if (oct == OCT_LOW)       return mid << 1;
    else if (oct == OCT_HIGH) return mid >> 1;
    else                      return mid;
  endfunction

endpackage

// File: rtl/spk_tone_gen.sv
// Purpose : square-wave generator; toggles speaker every hp cycles while enabled.
// Latency : first toggle hp edges after en rises; en low clears speaker on the next edge.
// Backpressure: none; free-running whenever en is high.
// Ports: clk, rst (sync, active-high), hp (half-period in cycles), en, speaker.
module spk_tone_gen #(
  parameter int HP_W = 19
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [HP_W-1:0] hp,
  input  logic            en,
  output logic            speaker
);

  logic [HP_W-1:0] tone_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tone_cnt <= '0;
      speaker  <= 1'b0;
    end else if (!en) begin
      tone_cnt <= '0;
      speaker  <= 1'b0;
    end else if (tone_cnt == hp - HP_W'(1)) begin
      tone_cnt <= '0;
      speaker  <= ~speaker;
    end else begin
      tone_cnt <= tone_cnt + HP_W'(1);
    end
  end

endmodule

// File: rtl/speaker_arbiter.sv
// Purpose : grants the single speaker to one of five note sources (mode mask + fixed priority), holds and gaps notes, makes the tone.
// Latency : 1 cycle from candidate request to grant; owner switch only after MIN_HOLD (mode change exits at once).
// Backpressure: level-based; losing or early-changing requesters simply wait, nothing is queued.
// Ports: clk, rst, mode, req, note_i, oct_i -> grant, busy, cur_note, cur_oct, speaker.
// Build option: define SPK_ARTIC_GAP_EN to insert GAP_CYC silent cycles between notes; otherwise PLAY exits straight to IDLE.
module speaker_arbiter
  import spk_pkg::*;
#(
  parameter int N_REQ    = 5,
  parameter int MIN_HOLD = 10_000_000,
  parameter int GAP_CYC  = 2_000_000,
  parameter int HP_W     = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           mode,
  input  logic [N_REQ-1:0]     req,
  input  logic [3*N_REQ-1:0]   note_i,
  input  logic [2*N_REQ-1:0]   oct_i,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic [2:0]           cur_note,
  output logic [1:0]           cur_oct,
  output logic                 speaker
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

`ifdef SPK_ARTIC_GAP_EN
  localparam arb_state_t PLAY_EXIT = S_GAP;
`else
  localparam arb_state_t PLAY_EXIT = S_IDLE;
`endif

  arb_state_t        state, state_nxt;
  logic [2:0]        mode_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [IDX_W-1:0]  own_idx;
  logic [N_REQ-1:0]  elig, cand, above;
  logic [IDX_W-1:0]  win_idx;
  logic [2:0]        win_note, own_note;
  logic [1:0]        win_oct, own_oct;
  logic              own_cand, any_cand, mode_chg, hold_done, release_ok;

  always_comb begin
    elig = '0;
    case (mode)
      MODE_FREE:   elig[0] = 1'b1;
      MODE_AUTO:   elig[1] = 1'b1;
      MODE_STUDY:  begin elig[2] = 1'b1; elig[0] = 1'b1; end
      MODE_RECORD: begin elig[3] = 1'b1; elig[0] = 1'b1; end
      MODE_READ:   elig[3] = 1'b1;
      MODE_ADJUST: elig[4] = 1'b1;
      default:     elig = '0;
    endcase
  end

  // Upward scan so the highest-index candidate is the last writer and wins.
  // The same loop pulls out the current owner's live request for the release test.
  always_comb begin
    cand     = '0;
    above    = '0;
    win_idx  = '0;
    win_note = N_SPACE;
    win_oct  = '0;
    own_note = N_SPACE;
    own_oct  = '0;
    own_cand = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand[k] = req[k] & elig[k] & (note_i[3*k +: 3] != N_SPACE);
      if (cand[k]) begin
        win_idx  = IDX_W'(k);
        win_note = note_i[3*k +: 3];
        win_oct  = oct_i[2*k +: 2];
      end
      above[k] = cand[k] && (k > int'(own_idx));
      if (IDX_W'(k) == own_idx) begin
        own_note = note_i[3*k +: 3];
        own_oct  = oct_i[2*k +: 2];
        own_cand = cand[k];
      end
    end
  end

  assign any_cand  = |cand;
  assign mode_chg  = (mode != mode_q);
  assign hold_done = (hold_cnt == HOLD_W'(MIN_HOLD));
  // Before the hold expires none of these may cut the note short.
  assign release_ok = hold_done &&
                      (!own_cand || (own_note != cur_note) || (own_oct != cur_oct) || (|above));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_cand) state_nxt = S_PLAY;
      S_PLAY:  if (mode_chg || release_ok) state_nxt = PLAY_EXIT;
      S_GAP:   if (!mode_chg && (gap_cnt == GAP_W'(GAP_CYC - 1))) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      own_idx  <= '0;
      cur_note <= N_SPACE;
      cur_oct  <= '0;
    end else begin
      mode_q <= mode;
      case (state)
        S_IDLE: begin
          gap_cnt <= '0;
          if (any_cand) begin
            own_idx  <= win_idx;
            cur_note <= win_note;
            cur_oct  <= win_oct;
            hold_cnt <= '0;
          end
        end
        S_PLAY: begin
          gap_cnt <= '0;
          if (!hold_done) hold_cnt <= hold_cnt + HOLD_W'(1);
        end
        S_GAP: begin
          // A mode change restarts the silence so the new mode gets a clean gap.
          if (mode_chg || (gap_cnt == GAP_W'(GAP_CYC - 1))) gap_cnt <= '0;
          else                                             gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: gap_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    grant = '0;
    if (state == S_PLAY) grant[own_idx] = 1'b1;
  end

  assign busy = (state != S_IDLE);

  spk_tone_gen #(
    .HP_W (HP_W)
  ) u_tone (
    .clk     (clk),
    .rst     (rst),
    .hp      (HP_W'(hp_of(cur_note, cur_oct))),
    .en      (state == S_PLAY),
    .speaker (speaker)
  );

endmodule

// File: tb/tb_speaker_arbiter.sv
// Purpose : self-checking bench for speaker_arbiter against a cycle-level reference model.
// Latency : model advances once per rising edge; outputs sampled 1 ns after the edge.
// Backpressure: n/a.
module tb_speaker_arbiter;
  import spk_pkg::*;

  localparam int N_REQ    = 5;
  localparam int MIN_HOLD = 100;
  localparam int GAP_CYC  = 20;
  localparam int HP_W     = 19;
`ifdef SPK_ARTIC_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode;
  logic [4:0]  req;
  logic [14:0] note_i;
  logic [9:0]  oct_i;
  logic [4:0]  grant;
  logic        busy;
  logic [2:0]  cur_note;
  logic [1:0]  cur_oct;
  logic        speaker;

  int checks = 0;
  int errors = 0;

  // Reference model state: phase 0 idle, 1 playing, 2 silent gap.
  int         m_phase, m_own, m_hold, m_gap, m_age;
  logic [2:0] m_note, m_mode_q;
  logic [1:0] m_oct;

  speaker_arbiter #(
    .N_REQ(N_REQ), .MIN_HOLD(MIN_HOLD), .GAP_CYC(GAP_CYC), .HP_W(HP_W)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .req(req), .note_i(note_i), .oct_i(oct_i),
    .grant(grant), .busy(busy), .cur_note(cur_note), .cur_oct(cur_oct), .speaker(speaker)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000_000;
    $display("FAIL watchdog time limit expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic int ref_hp(input logic [2:0] n, input logic [1:0] o);
    int tbl [8] = '{0, 190840, 170068, 151515, 143266, 127551, 113636, 101214};
    if (o == 2'b10) return tbl[n] * 2;
    if (o == 2'b01) return tbl[n] / 2;
    return tbl[n];
  endfunction

  function automatic logic [4:0] elig_of(input logic [2:0] md);
    case (md)
      3'b001:  return 5'b00001;
      3'b010:  return 5'b00010;
      3'b100:  return 5'b00101;
      3'b011:  return 5'b01001;
      3'b111:  return 5'b01000;
      3'b101:  return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic void model_step();
    logic [4:0] el;
    int win;
    bit chg, is_cand, leave;
    logic [2:0] on;
    logic [1:0] oo;
    if (rst) begin
      m_phase = 0; m_own = 0; m_hold = 0; m_gap = 0; m_age = 0;
      m_note = 3'd0; m_oct = 2'd0; m_mode_q = 3'd0;
      return;
    end
    el  = elig_of(mode);
    win = -1;
    for (int k = 0; k < N_REQ; k++)
      if (req[k] && el[k] && note_i[3*k +: 3] != 3'd0) win = k;
    chg = (mode != m_mode_q);
    case (m_phase)
      0: if (win >= 0) begin
        m_phase = 1; m_own = win; m_hold = 0; m_age = 0;
        m_note = note_i[3*win +: 3]; m_oct = oct_i[2*win +: 2];
      end
      1: begin
        on = note_i[3*m_own +: 3];
        oo = oct_i[2*m_own +: 2];
        is_cand = req[m_own] && el[m_own] && (on != 3'd0);
        leave = chg || ((m_hold == MIN_HOLD) &&
                        (!is_cand || on != m_note || oo != m_oct || win > m_own));
        if (leave) begin
          m_phase = GAP_EN ? 2 : 0;
          m_gap   = 0;
        end else begin
          if (m_hold < MIN_HOLD) m_hold++;
          m_age++;
        end
      end
      default: begin
        if (chg)                     m_gap = 0;
        else if (m_gap == GAP_CYC-1) m_phase = 0;
        else                         m_gap++;
      end
    endcase
    m_mode_q = mode;
  endfunction

  // Expected {grant, busy, cur_note, cur_oct, speaker}.
  function automatic logic [11:0] m_vec();
    logic [4:0] g;
    logic       s;
    g = (m_phase == 1) ? 5'(1 << m_own) : 5'b0;
    s = (m_phase == 1) ? (((m_age / ref_hp(m_note, m_oct)) % 2) == 1) : 1'b0;
    return {g, (m_phase != 0), m_note, m_oct, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_src(input int k, input logic [2:0] n, input logic [1:0] o);
    note_i[3*k +: 3] = n;
    oct_i[2*k +: 2]  = o;
  endtask

  task automatic do_reset();
    rst = 1'b1; mode = 3'b000; req = '0; note_i = '0; oct_i = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 3'b001; req = 5'b11111; note_i = '1; oct_i = '0;
    repeat (2) tick();
    checks++;
    if ({grant, busy, cur_note, cur_oct, speaker} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state got=%h exp=000", {grant, busy, cur_note, cur_oct, speaker});
    end
    rst = 1'b0; req = '0; note_i = '0;
  endtask

  task automatic test_free();
    do_reset();
    mode = 3'b001; req = 5'b00001; set_src(0, 3'd1, 2'b00);
    tick();
    checks++;
    if (grant !== 5'b00001 || cur_note !== 3'd1) begin
      errors++;
      $display("FAIL free_grant_latency got grant=%b note=%0d exp grant=00001 note=1", grant, cur_note);
    end
    checks++;
    if (hp_of(3'd1, 2'b00) !== 19'd190840) begin
      errors++;
      $display("FAIL hp_do_mid got=%0d exp=190840", hp_of(3'd1, 2'b00));
    end
    for (int i = 0; i < 150; i++) begin
      tick();
      checks++;
      if ({grant, busy, cur_note, cur_oct, speaker} !== m_vec()) begin
        errors++;
        $display("FAIL free_play cyc=%0d got=%h exp=%h", i, {grant, busy, cur_note, cur_oct, speaker}, m_vec());
      end
    end
  endtask

  task automatic test_priority();
    int first, zeros;
    do_reset();
    mode = 3'b100; req = 5'b00001; set_src(0, 3'd3, 2'b00); set_src(2, 3'd5, 2'b00);
    first = -1; zeros = 0;
    for (int t = 1; t <= 200; t++) begin
      if (t == 11) req[2] = 1'b1;
      tick();
      checks++;
      if ({grant, busy, cur_note, cur_oct, speaker} !== m_vec()) begin
        errors++;
        $display("FAIL prio_seq t=%0d got=%h exp=%h", t, {grant, busy, cur_note, cur_oct, speaker}, m_vec());
      end
      if (first < 0 && grant == 5'b00000 && t > 1) zeros++;
      if (first < 0 && grant == 5'b00100) first = t;
    end
    checks++;
    if (first != MIN_HOLD + 3 + (GAP_EN ? GAP_CYC : 0)) begin
      errors++;
      $display("FAIL prio_switch_time got=%0d exp=%0d", first, MIN_HOLD + 3 + (GAP_EN ? GAP_CYC : 0));
    end
    checks++;
    if (zeros != (GAP_EN ? GAP_CYC + 1 : 1) || cur_note !== 3'd5) begin
      errors++;
      $display("FAIL prio_gap_len got zeros=%0d note=%0d exp zeros=%0d note=5", zeros, cur_note,
               GAP_EN ? GAP_CYC + 1 : 1);
    end
  endtask

  task automatic test_note_change();
    do_reset();
    mode = 3'b001; req = 5'b00001; set_src(0, 3'd1, 2'b00);
    tick();
    for (int h = 1; h <= 200; h++) begin
      if (h == 41) set_src(0, 3'd2, 2'b00);
      tick();
      checks++;
      if ({grant, busy, cur_note, cur_oct, speaker} !== m_vec()) begin
        errors++;
        $display("FAIL note_change h=%0d got=%h exp=%h", h, {grant, busy, cur_note, cur_oct, speaker}, m_vec());
      end
      if (h == 99) begin
        checks++;
        if (cur_note !== 3'd1 || grant !== 5'b00001) begin
          errors++;
          $display("FAIL note_held got note=%0d grant=%b exp note=1 grant=00001", cur_note, grant);
        end
      end
    end
    checks++;
    if (cur_note !== 3'd2 || grant !== 5'b00001) begin
      errors++;
      $display("FAIL note_regrant got note=%0d grant=%b exp note=2 grant=00001", cur_note, grant);
    end
  endtask

  task automatic test_mode_change();
    do_reset();
    mode = 3'b001; req = 5'b00001; set_src(0, 3'd4, 2'b00);
    repeat (31) tick();
    mode = 3'b010;
    tick();
    checks++;
    if (grant !== 5'b0 || busy !== GAP_EN || speaker !== 1'b0) begin
      errors++;
      $display("FAIL mode_chg_exit got grant=%b busy=%b spk=%b exp grant=00000 busy=%b spk=0",
               grant, busy, speaker, GAP_EN);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({grant, busy, cur_note, cur_oct, speaker} !== m_vec()) begin
        errors++;
        $display("FAIL mode_chg_seq i=%0d got=%h exp=%h", i, {grant, busy, cur_note, cur_oct, speaker}, m_vec());
      end
    end
    checks++;
    if (grant !== 5'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ineligible_free got grant=%b busy=%b exp 00000 0", grant, busy);
    end
  endtask

  task automatic test_octave();
    checks++;
    if (hp_of(3'd6, 2'b10) !== 19'd227272) begin
      errors++;
      $display("FAIL hp_la_low got=%0d exp=227272", hp_of(3'd6, 2'b10));
    end
    checks++;
    if (hp_of(3'd6, 2'b01) !== 19'd56818) begin
      errors++;
      $display("FAIL hp_la_high got=%0d exp=56818", hp_of(3'd6, 2'b01));
    end
    do_reset();
    mode = 3'b001; req = 5'b00001; set_src(0, 3'd6, 2'b10);
    repeat (2) tick();
    checks++;
    if (cur_oct !== 2'b10 || cur_note !== 3'd6) begin
      errors++;
      $display("FAIL octave_latch got oct=%b note=%0d exp oct=10 note=6", cur_oct, cur_note);
    end
    do_reset();
    mode = 3'b110; req = 5'b11111; note_i = 15'o77777; oct_i = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (grant !== 5'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bad_mode_nogrant i=%0d got grant=%b busy=%b exp 00000 0", i, grant, busy);
      end
    end
  endtask

  task automatic test_reset_mid_play();
    do_reset();
    mode = 3'b001; req = 5'b00001; set_src(0, 3'd2, 2'b00);
    repeat (50) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({grant, busy, cur_note, cur_oct, speaker} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_play got=%h exp=000", {grant, busy, cur_note, cur_oct, speaker});
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] modes [8] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b111, 3'b101, 3'b110, 3'b000};
    do_reset();
    mode = 3'b001; req = 5'b00001; set_src(0, 3'd1, 2'b00);
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 59) == 0) mode = modes[$urandom_range(0, 7)];
      if ($urandom_range(0, 29) == 0) req[$urandom_range(0, 4)] ^= 1'b1;
      if ($urandom_range(0, 39) == 0)
        set_src($urandom_range(0, 4), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      tick();
      checks++;
      if ({grant, busy, cur_note, cur_oct, speaker} !== m_vec()) begin
        errors++;
        $display("FAIL random i=%0d got=%h exp=%h", i, {grant, busy, cur_note, cur_oct, speaker}, m_vec());
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_tone_long();
    do_reset();
    mode = 3'b001; req = 5'b00001; set_src(0, 3'd7, 2'b01);
    for (int i = 0; i < 50700; i++) begin
      tick();
      checks++;
      if ({grant, busy, cur_note, cur_oct, speaker} !== m_vec()) begin
        errors++;
        $display("FAIL tone i=%0d got=%h exp=%h", i, {grant, busy, cur_note, cur_oct, speaker}, m_vec());
      end
    end
    checks++;
    if (speaker !== 1'b1) begin
      errors++;
      $display("FAIL tone_toggled got=%b exp=1", speaker);
    end
  endtask

  initial begin
    rst = 1'b1; mode = '0; req = '0; note_i = '0; oct_i = '0;
    test_reset();
    test_free();
    test_priority();
    test_note_change();
    test_mode_change();
    test_octave();
    test_reset_mid_play();
    test_random();
    test_tone_long();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/speaker_arbiter.md
Name: speaker_arbiter

Overview:
- Shares the single speaker output between the five note sources of the piano: free, auto, study, record and adjust.
- Each source requests the speaker with a note code and an octave. The arbiter picks one winner per playback, based on the current mode and a fixed priority.
- It enforces a minimum note hold and an articulation gap, and generates the square-wave tone itself.
- It replaces the mux-only speaker path under the top level.

Parameters:
- N_REQ, 5, number of requesters. Bit order: 0 free, 1 auto, 2 study, 3 record, 4 adjust.
- MIN_HOLD, 10_000_000, minimum PLAY duration in clk cycles (100 ms at 100 MHz).
- GAP_CYC, 2_000_000, silent cycles between two granted notes (20 ms).
- HP_W, 19, width of the half-period counter.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- mode  in  3  001 free, 010 auto, 100 study, 011 record, 111 read, 101 adjust
- req  in  N_REQ  per-source request level
- note_i  in  3*N_REQ  packed note codes; source k occupies [3k+2:3k]; 0 space, 1..7 do..si
- oct_i  in  2*N_REQ  packed octaves; 2'b10 low, 2'b01 high, otherwise middle
- grant  out  N_REQ  one-hot current owner, or 0
- busy  out  1  high while in PLAY or GAP
- cur_note  out  3  latched note of the owner; drives the 7-segment display
- cur_oct  out  2  latched octave of the owner
- speaker  out  1  square-wave tone

Behaviour:
- Eligibility mask, decoded from mode:
  - 001 → {0}
  - 010 → {1}
  - 100 → {2, 0}
  - 011 → {3, 0}
  - 111 → {3}
  - 101 → {4}
  - any other code → {}
- A source is a candidate when req[k], eligible[k] and note_k≠0 are all true. Priority: the highest index wins.
- FSM: IDLE, PLAY, GAP. On reset: IDLE, grant=0, busy=0, cur_note=0, cur_oct=0, speaker=0, all counters 0.
- IDLE:
  - If any candidate exists, on the next edge: grant the winner, latch its note and octave, set hold_cnt=0 and tone_cnt=0 with speaker=0, then go to PLAY.
  - Latency from req to grant is 1 cycle.
- PLAY:
  - hold_cnt increments and saturates at MIN_HOLD.
  - Go to GAP when hold_cnt==MIN_HOLD and any of the following is true:
    - the owner stops being a candidate;
    - the owner's note or octave differs from the latched value;
    - a higher-priority candidate exists.
  - Before the hold expires, these events are ignored and the latched note continues to sound.
- Mode change: if mode differs from the value registered last cycle while in PLAY, go to GAP immediately, regardless of hold.
- GAP:
  - grant=0, speaker=0, cur_note is kept, gap_cnt counts to GAP_CYC-1, then go to IDLE.
  - A mode change during GAP restarts gap_cnt.
- Tone generation:
  - Middle-octave half-periods in cycles: do 190840, re 170068, mi 151515, fa 143266, so 127551, la 113636, si 101214.
  - Low octave: half-period << 1. High octave: half-period >> 1.
  - In PLAY, tone_cnt counts 0..hp-1; at hp-1 it wraps to 0 and speaker toggles.
  - Outside PLAY, tone_cnt=0 and speaker=0.
- Simultaneous requests in IDLE: the highest index wins.
- A requester that holds req continuously after its note ends is re-granted only after the gap.
- Reset in any state forces the reset values on the next edge.

Optional Feature:
- Macro: SPK_ARTIC_GAP_EN.
- Defined: the GAP state exists as described above.
- Undefined:
  - PLAY exit conditions go straight to IDLE, and GAP_CYC is unused.
  - A new grant still forces one speaker=0 cycle, because IDLE→PLAY costs one edge.

Decomposition:
- Package spk_pkg holds:
  - note codes N_SPACE..N_SI;
  - octave codes OCT_LOW, OCT_HIGH;
  - mode codes MODE_FREE..MODE_READ;
  - the half-period table as a function hp_of(note, oct);
  - FSM state typedef arb_state_t.
- One sub-module, spk_tone_gen (inputs: hp, en; output: speaker), holds tone_cnt and the toggle.
- Arbitration and the FSM remain in speaker_arbiter.

Test Plan (bench parameters MIN_HOLD=100, GAP_CYC=20):
- mode=001, req[0]=1, note0=1, oct0=00 → grant=00001 after 1 cycle; speaker toggles every 190840 cycles; cur_note=1.
- mode=100; req[0] note 3 at t0, req[2] note 5 at t0+10 → grant stays 00001 until hold=100, then 20 cycles with grant=0 and speaker=0, then grant=00100 and cur_note=5.
- mode=001; owner changes its note 1→2 at hold=40 → note 1 continues to sound until hold=100; then GAP, then cur_note=2.
- Owner in PLAY at hold=30, mode changes 001→010 → GAP entered the next cycle; after 20 cycles IDLE; a free request is ignored (not eligible).
- oct0=10, note 6 → half-period 227272; oct0=01 → half-period 56818; mode=110 with all req high → grant stays 0.
- rst=1 for 1 cycle in mid-PLAY → next edge grant=0, busy=0, speaker=0, cur_note=0; without SPK_ARTIC_GAP_EN, scenario 2 switches owner with no 20-cycle gap.
